// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM RW0 access controller.
package sram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  // Constant-evaluable ceil(log2(v)); independent of any data width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_read_hold.sv
// Read response channel: in-flight flag, hold register for backpressure,
// and bypass/hold mux so read data stays stable while the consumer stalls.
module sram_read_hold
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 261
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_issue,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              r_resp_ready,
  output logic              r_resp_valid,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              inflight,
  output logic              hold_valid
);

  logic [DATA_W-1:0] hold_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight   <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      inflight <= rd_issue;
      // The macro only presents rdata for one cycle, so capture it on a stall.
      if (inflight && !r_resp_ready) begin
        hold_valid <= 1'b1;
        hold_data  <= sram_rdata;
      end else if (r_resp_ready) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Masked during reset so a read killed by reset never produces a response.
  assign r_resp_valid = !reset && (inflight || hold_valid);
  assign r_resp_data  = hold_valid ? hold_data : (inflight ? sram_rdata : '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Drives the RW0 port of a 1-cycle-latency SRAM macro from ready/valid read
// and write request channels, with optional zero-fill after reset.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int ADDR_W        = clog2(DEPTH),
  parameter int DATA_W        = 261,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [DATA_W-1:0] w_req_data,
  output logic              r_resp_valid,
  input  logic              r_resp_ready,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic              sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  // Handshake: every channel transfers on a cycle where valid && ready; valid
  // never depends on ready, and a held response keeps valid and data stable
  // until it is accepted.

  ctrl_state_t       state;
  logic [ADDR_W-1:0] cnt;
  logic              run;
  logic              w_fire;
  logic              rd_issue;
  logic              inflight;
  logic              hold_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt       <= '0;
      init_done <= (INIT_ON_RESET == 0);
    end else if (state == ST_INIT) begin
      cnt <= cnt + ADDR_W'(1);
      if (cnt == ADDR_W'(DEPTH - 1)) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end
  end

  // Writes win arbitration; a read also needs the response path to be free.
  assign run         = (state == ST_RUN) && !reset;
  assign w_req_ready = run;
  assign r_req_ready = run && !w_req_valid && !hold_valid && (!inflight || r_resp_ready);
  assign w_fire      = w_req_valid && w_req_ready;
  assign rd_issue    = r_req_valid && r_req_ready;

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_wmask = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!reset) begin
      if (state == ST_INIT) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_wmask = 1'b1;
        sram_addr  = cnt;
      end else if (w_fire) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_wmask = 1'b1;
        sram_addr  = w_req_addr;
        sram_wdata = w_req_data;
      end else if (rd_issue) begin
        sram_en    = 1'b1;
        sram_addr  = r_req_addr;
      end
    end
  end

  sram_read_hold #(
    .DATA_W(DATA_W)
  ) u_read_hold (
    .clock       (clock),
    .reset       (reset),
    .rd_issue    (rd_issue),
    .sram_rdata  (sram_rdata),
    .r_resp_ready(r_resp_ready),
    .r_resp_valid(r_resp_valid),
    .r_resp_data (r_resp_data),
    .inflight    (inflight),
    .hold_valid  (hold_valid)
  );

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_sram_access_ctrl;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 261;

  logic              clock;
  logic              reset;
  logic              r_req_valid;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_req_addr;
  logic              w_req_valid;
  logic              w_req_ready;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_data;
  logic              r_resp_valid;
  logic              r_resp_ready;
  logic [DATA_W-1:0] r_resp_data;
  logic              init_done;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic              sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  int n_checks;
  int n_errors;
  int resp_count;

  sram_access_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_ON_RESET(1)
  ) dut (
    .clock(clock), .reset(reset),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
    .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_addr(w_req_addr),
    .w_req_data(w_req_data),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp_data(r_resp_data),
    .init_done(init_done),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // SRAM model: rdata is garbage except in the cycle after a read issue.
  always @(posedge clock) begin
    if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
    else                        sram_rdata <= {DATA_W{1'b1}};
    if (sram_en && sram_wmode && sram_wmask) mem[sram_addr] <= sram_wdata;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted response must match the head of exp_q.
  always @(negedge clock) begin
    if (r_resp_valid && r_resp_ready) begin
      resp_count++;
      check("resp_pending", DATA_W'(exp_q.size() != 0), DATA_W'(1));
      if (exp_q.size() != 0) check("resp_data", r_resp_data, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    w_req_valid = 1'b1;
    w_req_addr  = a;
    w_req_data  = d;
    @(negedge clock);
    check("w_ready", DATA_W'(w_req_ready), DATA_W'(1));
    step();
    w_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    r_req_valid = 1'b1;
    r_req_addr  = a;
    @(negedge clock);
    check("r_ready", DATA_W'(r_req_ready), DATA_W'(1));
    check("rd_issue_wmode", DATA_W'(sram_wmode), DATA_W'(0));
    exp_q.push_back(exp);
    step();
    r_req_valid = 1'b0;
    @(negedge clock);
    check("resp_valid_t1", DATA_W'(r_resp_valid), DATA_W'(1));
    step();
  endtask

  task automatic check_init_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      check("init_en", DATA_W'(sram_en), DATA_W'(1));
      check("init_wmode", DATA_W'(sram_wmode), DATA_W'(1));
      check("init_wdata", sram_wdata, '0);
      check("init_addr", DATA_W'(sram_addr), DATA_W'(i));
      check("init_done_low", DATA_W'(init_done), DATA_W'(0));
      check("init_readies", DATA_W'({r_req_ready, w_req_ready}), DATA_W'(0));
      step();
    end
    @(negedge clock);
    check("init_done_high", DATA_W'(init_done), DATA_W'(1));
    check("run_w_ready", DATA_W'(w_req_ready), DATA_W'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_errors = 0; resp_count = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {DATA_W{1'b1}};
    sram_rdata = '0;
    reset = 1'b1;
    r_req_valid = 1'b0; r_req_addr = '0;
    w_req_valid = 1'b0; w_req_addr = '0; w_req_data = '0;
    r_resp_ready = 1'b1;
    step();
    step();
    @(negedge clock);
    check("rst_init_done", DATA_W'(init_done), DATA_W'(0));
    check("rst_resp_valid", DATA_W'(r_resp_valid), DATA_W'(0));
    check("rst_readies", DATA_W'({r_req_ready, w_req_ready}), DATA_W'(0));
    step();
    reset = 1'b0;

    // 1: zero-fill sweep, then addr 3 reads back zero
    check_init_sweep();
    step();
    do_read(2'd3, '0);

    // 2: write then read
    do_write(2'd2, DATA_W'(36'h1_DEAD_BEEF));
    do_read(2'd2, DATA_W'(36'h1_DEAD_BEEF));

    // 3: back-to-back reads at full rate
    for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), DATA_W'(4'hA + i));
    resp_count = 0;
    r_req_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      r_req_addr = ADDR_W'(i);
      @(negedge clock);
      check("b2b_r_ready", DATA_W'(r_req_ready), DATA_W'(1));
      exp_q.push_back(DATA_W'(4'hA + i));
      step();
    end
    r_req_valid = 1'b0;
    @(negedge clock);
    step();
    check("b2b_resp_count", DATA_W'(resp_count), DATA_W'(DEPTH));

    // 4: backpressure with a write to the same address during the stall
    do_write(2'd1, DATA_W'(8'h55));
    r_resp_ready = 1'b0;
    r_req_valid = 1'b1;
    r_req_addr  = 2'd1;
    @(negedge clock);
    check("bp_r_ready", DATA_W'(r_req_ready), DATA_W'(1));
    exp_q.push_back(DATA_W'(8'h55));
    step();
    r_req_valid = 1'b0;
    w_req_valid = 1'b1; w_req_addr = 2'd1; w_req_data = DATA_W'(8'h77);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_valid", DATA_W'(r_resp_valid), DATA_W'(1));
      check("bp_data", r_resp_data, DATA_W'(8'h55));
      check("bp_r_ready_low", DATA_W'(r_req_ready), DATA_W'(0));
      step();
      w_req_valid = 1'b0;
      r_req_valid = 1'b1;
    end
    r_resp_ready = 1'b1;
    @(negedge clock);
    check("drain_r_ready_low", DATA_W'(r_req_ready), DATA_W'(0));
    step();
    r_req_valid = 1'b0;
    do_read(2'd1, DATA_W'(8'h77));

    // 5: simultaneous read and write, write wins
    r_req_valid = 1'b1; r_req_addr = 2'd0;
    w_req_valid = 1'b1; w_req_addr = 2'd0; w_req_data = DATA_W'(4'h9);
    @(negedge clock);
    check("arb_w_ready", DATA_W'(w_req_ready), DATA_W'(1));
    check("arb_r_ready_low", DATA_W'(r_req_ready), DATA_W'(0));
    check("arb_wmode", DATA_W'(sram_wmode), DATA_W'(1));
    step();
    w_req_valid = 1'b0;
    r_req_valid = 1'b0;
    do_read(2'd0, DATA_W'(4'h9));

    // 6: reset the cycle after a read issue; no response may appear
    resp_count = 0;
    r_req_valid = 1'b1; r_req_addr = 2'd2;
    @(negedge clock);
    check("rst6_r_ready", DATA_W'(r_req_ready), DATA_W'(1));
    step();
    r_req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("rst6_no_resp", DATA_W'(r_resp_valid), DATA_W'(0));
    step();
    reset = 1'b0;
    check_init_sweep();
    step();
    check("rst6_resp_count", DATA_W'(resp_count), DATA_W'(0));
    check("final_q_empty", DATA_W'(exp_q.size()), DATA_W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
Requester-side controller that drives the RW0 port of a single-port, 1-cycle-read-latency SRAM macro (depth x width, one whole-word mask bit). It converts independent ready/valid read and write request channels into RW0 cycles and zero-fills the array after reset. It returns read data on a ready/valid response channel, holding data stable under backpressure. It sits between cache/predictor logic and the generated `*_ext` array macros.

Parameters:
DEPTH, 4, number of SRAM entries
ADDR_W, 2, address width, equal to clog2(DEPTH)
DATA_W, 261, word width
INIT_ON_RESET, 1, when 1, zero-fill all entries after reset before accepting requests

Ports:
clock  in  1  sole clock; also drives the SRAM macro RW0_clk
reset  in  1  synchronous, active-high
r_req_valid  in  1  read request valid
r_req_ready  out  1  read request accepted when valid&&ready
r_req_addr  in  ADDR_W  read address
w_req_valid  in  1  write request valid
w_req_ready  out  1  write request accepted when valid&&ready
w_req_addr  in  ADDR_W  write address
w_req_data  in  DATA_W  write data
r_resp_valid  out  1  read data valid
r_resp_ready  in  1  consumer accepts read data
r_resp_data  out  DATA_W  read data
init_done  out  1  high once the zero-fill is complete
sram_addr  out  ADDR_W  to RW0_addr
sram_en  out  1  to RW0_en
sram_wmode  out  1  to RW0_wmode
sram_wmask  out  1  to RW0_wmask
sram_wdata  out  DATA_W  to RW0_wdata
sram_rdata  in  DATA_W  from RW0_rdata; valid only in the cycle after a read issue

Behaviour:
- States: INIT, RUN. On reset: state=INIT when INIT_ON_RESET=1, otherwise RUN. Also on reset: init counter=0, inflight=0, hold_valid=0, init_done=0 (1 if INIT_ON_RESET=0), r_resp_valid=0, both readies=0.
- INIT: each cycle drives sram_en=1, wmode=1, wmask=1, wdata=0, addr=cnt, and increments cnt. When cnt==DEPTH-1, the next state is RUN and init_done=1. INIT therefore lasts exactly DEPTH cycles. Both request readies are 0 throughout INIT.
- RUN, write path: w_req_ready=1. An accepted write drives en=1, wmode=1, wmask=1, addr/wdata from the request in the same cycle (combinational issue).
- RUN, arbitration: write has priority. r_req_ready = !w_req_valid && !hold_valid && (!inflight || r_resp_ready). Sustained writes may starve reads; this is the documented contract.
- Read issue at cycle T: en=1, wmode=0, addr=r_req_addr. inflight is set for T+1.
- Response at T+1: r_resp_valid=1 and r_resp_data=sram_rdata (bypass path).
  - If r_resp_ready=0 at T+1, capture sram_rdata into the hold register and set hold_valid.
  - While hold_valid, r_resp_data comes from the hold register and r_resp_valid=1. hold_valid clears on r_resp_ready.
  - Data must stay stable under backpressure, even if writes to the same address or any other SRAM cycles occur meanwhile.
- Read data reflects array contents at the issue cycle T. A write at T+1 to the same address does not alter the returned data.
- Idle cycles: sram_en=0. sram_wmode, sram_addr and sram_wdata are don't-care but driven deterministically: 0, 0 and 0.
- Throughput: 1 read per cycle when r_resp_ready=1 and there are no writes; 1 write per cycle always in RUN.
- Reset mid-operation: in-flight read and held data are discarded with no response, and INIT restarts from cnt=0.
- Address out of range (>= DEPTH when DEPTH is not a power of two) is a caller error and is not checked.

Decomposition:
- Shared package sram_ctrl_pkg holds the state enum (INIT, RUN) and a DATA_W-independent helper for clog2.
- One natural sub-module, sram_read_hold: the inflight flag, hold register, and bypass/hold mux for the response channel.
- The top level holds the init FSM, arbitration, and RW0 drive.

Test Plan:
1. Reset with INIT_ON_RESET=1 -> cycles 0..3 show en=1, wmode=1, wdata=0, addr=0,1,2,3; init_done rises on cycle 4; readies are 0 before that; a read of addr 3 afterwards returns 0.
2. Write addr 2 data 0x1_DEAD_BEEF, then read addr 2 with r_resp_ready=1 -> r_resp_valid one cycle after the read handshake, data 0x1_DEAD_BEEF.
3. Back-to-back reads of addr 0,1,2,3 (preloaded 0xA,0xB,0xC,0xD) with r_resp_ready=1 -> four consecutive responses 0xA..0xD, with r_req_ready held at 1.
4. Read addr 1 (=0x55), hold r_resp_ready=0 for 3 cycles, writing addr 1 to 0x77 during the stall -> r_resp_data stays 0x55, r_req_ready=0 until drain, and a subsequent read returns 0x77.
5. Simultaneous r_req_valid (addr 0) and w_req_valid (addr 0, data 0x9) -> write accepted first with r_req_ready=0; the read is accepted the next cycle and returns 0x9.
6. Assert reset for 1 cycle the cycle after a read issue -> no r_resp_valid is produced, the INIT sweep restarts, and init_done falls to 0 then rises after DEPTH cycles.
